// File: rtl/helen_led_seq_pkg.sv
// Shared constants and types for the HELEN LED pattern sequencer.
// Register offsets, CTRL/STATUS bit positions and the FSM state type.
package helen_led_seq_pkg;

    localparam logic [3:0] REG_CTRL       = 4'd0;
    localparam logic [3:0] REG_PERIOD     = 4'd1;
    localparam logic [3:0] REG_LENGTH     = 4'd2;
    localparam logic [3:0] REG_STATUS     = 4'd3;
    localparam logic [3:0] REG_TABLE_BASE = 4'd8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Number of table entries actually stepped through: 0 means 1, capped at depth.
    function automatic logic [3:0] eff_length(input logic [3:0] len, input logic [3:0] depth);
        if (len == 4'd0)  return 4'd1;
        if (len > depth)  return depth;
        return len;
    endfunction

endpackage

// File: rtl/helen_led_seq_if.sv
// Bus bundle for helen_led_seq: CPU-side Avalon-MM slave and PIO-side Avalon-MM master.
// Modport slave is the sequencer's view; master is the view of whatever drives it.
interface helen_led_seq_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport slave (
        input  address, chipselect, write_n, writedata, avm_waitrequest,
        output readdata, avm_address, avm_write, avm_writedata
    );

    modport master (
        output address, chipselect, write_n, writedata, avm_waitrequest,
        input  readdata, avm_address, avm_write, avm_writedata
    );
endinterface

// File: rtl/helen_led_seq_timer.sv
// Loadable step-period down-counter. A period of 0 behaves as 1; expire_o also
// fires on the load cycle itself when the period is a single cycle.
module helen_led_seq_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                expire_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] eff;

    assign eff = (period_i == '0) ? PERIOD_W'(1) : period_i;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = eff - PERIOD_W'(1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - PERIOD_W'(1);
    end

    // Counting lasts eff-1 cycles after load so acceptances land exactly eff cycles apart.
    assign expire_o = load_i ? (eff == PERIOD_W'(1)) : (en_i && cnt_q <= PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/helen_led_seq.sv
// Autonomous LED pattern sequencer: CPU-loaded table stepped out to the PIO data_out register.
// Optional level interrupt on one-shot completion when HELEN_LED_SEQ_IRQ_EN is defined.
module helen_led_seq
    import helen_led_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 24
) (
    input  logic           clk,
    input  logic           reset,
`ifdef HELEN_LED_SEQ_IRQ_EN
    output logic           irq,
`endif
    helen_led_seq_if.slave bus
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_e                    state_q, state_d;
    logic                      enable_q, enable_d;
    logic                      oneshot_q, oneshot_d;
    logic                      done_q, done_d;
    logic [PERIOD_W-1:0]       period_q, period_d;
    logic [3:0]                length_q, length_d;
    logic [2:0]                idx_q, idx_d;
    logic [7:0]                wdata_q, wdata_d;
    logic [DEPTH-1:0][7:0]     table_q, table_d;

    logic       wr_en, ctrl_wr, period_wr, length_wr, status_wr, table_wr, table_hit;
    logic       busy, start, en_w, fsm_clr, step;
    logic       tmr_load, tmr_en, tmr_expire, avm_write;
    logic [3:0] len_eff;
    logic       last;
    logic [2:0] idx_n;
    logic [31:0] rdata;
    logic       unused_wd;

    assign unused_wd = ^bus.writedata;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign table_hit = bus.address[3] && ({1'b0, bus.address[2:0]} < DEPTH_L);
    assign ctrl_wr   = wr_en && (bus.address == REG_CTRL);
    assign period_wr = wr_en && (bus.address == REG_PERIOD);
    assign length_wr = wr_en && (bus.address == REG_LENGTH);
    assign status_wr = wr_en && (bus.address == REG_STATUS);
    assign table_wr  = wr_en && table_hit;

    assign busy    = (state_q != IDLE);
    assign start   = ctrl_wr && bus.writedata[CTRL_EN] && !busy;
    assign len_eff = eff_length(length_q, DEPTH_L);
    assign last    = ({1'b0, idx_q} >= (len_eff - 4'd1));
    assign idx_n   = last ? 3'd0 : idx_q + 3'd1;

    // Slave-side register updates; en_w is enable as the CPU leaves it this cycle.
    always_comb begin
        en_w      = enable_q;
        oneshot_d = oneshot_q;
        period_d  = period_q;
        length_d  = length_q;
        table_d   = table_q;
        if (ctrl_wr) begin
            oneshot_d = bus.writedata[CTRL_ONESHOT];
            if (!bus.writedata[CTRL_EN]) en_w = 1'b0;
            else if (!busy)              en_w = 1'b1;
        end
        if (period_wr) period_d = bus.writedata[PERIOD_W-1:0];
        if (length_wr) length_d = bus.writedata[3:0];
        if (table_wr)  table_d[bus.address[IDX_W-1:0]] = bus.writedata[7:0];
    end

    assign enable_d = en_w & ~fsm_clr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        done_d    = done_q;
        fsm_clr   = 1'b0;
        step      = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        avm_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = 3'd0;
                    wdata_d = table_q[0];
                    done_d  = 1'b0;
                end
            end
            ISSUE: begin
                // The request stays up until accepted, even if enable has dropped.
                avm_write = 1'b1;
                if (!bus.avm_waitrequest) begin
                    tmr_load = 1'b1;
                    if (!en_w)           state_d = IDLE;
                    else if (tmr_expire) step    = 1'b1;
                    else                 state_d = WAIT;
                end
            end
            WAIT: begin
                tmr_en = 1'b1;
                if (!en_w)           state_d = IDLE;
                else if (tmr_expire) step    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (step) begin
            if (oneshot_d && last) begin
                state_d = IDLE;
                done_d  = 1'b1;
                fsm_clr = 1'b1;
            end else begin
                state_d = ISSUE;
                idx_d   = idx_n;
                wdata_d = table_q[idx_n[IDX_W-1:0]];
            end
        end
        if (status_wr) done_d = 1'b0;
    end

    helen_led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .period_i (period_q),
        .expire_o (tmr_expire)
    );

`ifdef HELEN_LED_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    assign irq_en_d = ctrl_wr ? bus.writedata[CTRL_IRQ_EN] : irq_en_q;
    assign irq_d    = done_q & irq_en_q;
    assign irq      = irq_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            REG_CTRL: begin
                rdata[CTRL_EN]      = enable_q;
                rdata[CTRL_ONESHOT] = oneshot_q;
`ifdef HELEN_LED_SEQ_IRQ_EN
                rdata[CTRL_IRQ_EN]  = irq_en_q;
`endif
            end
            REG_PERIOD: rdata[PERIOD_W-1:0] = period_q;
            REG_LENGTH: rdata[3:0]          = length_q;
            REG_STATUS: begin
                rdata[STAT_BUSY]                    = busy;
                rdata[STAT_DONE]                    = done_q;
                rdata[STAT_IDX_LSB+2:STAT_IDX_LSB]  = idx_q;
            end
            default: if (table_hit) rdata[7:0] = table_q[bus.address[IDX_W-1:0]];
        endcase
    end

    assign bus.readdata      = rdata;
    assign bus.avm_address   = 2'd0;
    assign bus.avm_write     = avm_write;
    assign bus.avm_writedata = {24'd0, wdata_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
            done_q    <= 1'b0;
            period_q  <= '0;
            length_q  <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            table_q   <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            oneshot_q <= oneshot_d;
            done_q    <= done_d;
            period_q  <= period_d;
            length_q  <= length_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            table_q   <= table_d;
        end
    end

endmodule

// File: doc/helen_led_seq.md
Name: helen_led_seq

Overview:
- Autonomous pattern sequencer that drives the 8-bit LED PIO over an Avalon-MM master port. It writes PIO register 0 (data_out).
- The CPU loads a small pattern table and step period through an Avalon-MM slave. The block then steps through the table in loop or one-shot mode without CPU involvement.
- Sits in the HELEN Qsys system between the Nios data master fabric (slave side) and the LED PIO s1 (master side).

Parameters:
- DEPTH, 8: pattern table entries; power of 2, 2..8.
- PERIOD_W, 24: width of the step-period register in clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- address  in  4  slave word address.
- chipselect  in  1  slave select.
- write_n  in  1  slave write strobe, active-low.
- writedata  in  32  slave write data.
- readdata  out  32  slave read data; combinational, zero wait states.
- avm_address  out  2  master word address; constant 0 (PIO data_out).
- avm_write  out  1  master write request.
- avm_writedata  out  32  master data: {24'b0, pattern}.
- avm_waitrequest  in  1  PIO/fabric stall.

Behaviour:
- Reset: one clock, reset is synchronous and active-high.
  - Reset clears all registers, the table and the FSM; state goes to IDLE.
  - avm_write=0, avm_writedata=0, avm_address=0.
  - readdata: CTRL, PERIOD and LENGTH read back their reset values (0); STATUS reads 0.
- Register map (slave write = chipselect & ~write_n):
  - 0 CTRL: [0] enable, [1] oneshot.
  - 1 PERIOD: [PERIOD_W-1:0] cycles per step; 0 is treated as 1.
  - 2 LENGTH: [3:0] active entries; 0 is treated as 1; values above DEPTH are clamped to DEPTH.
  - 3 STATUS (RO): [0] busy, [1] done, [6:4] current index. Any write to STATUS clears done.
  - 8..8+DEPTH-1: pattern[i][7:0], read/write.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states:
  - IDLE: a CTRL write with enable=1 loads idx=0, clears done and goes to ISSUE on the next cycle.
  - ISSUE: avm_write=1 and avm_writedata=pattern[idx]. Both are held stable while avm_waitrequest=1. When the write is accepted (avm_write & ~avm_waitrequest), go to WAIT and load the period counter.
  - WAIT: counts down the period.
    - If the last entry was just issued and oneshot=1: clear enable, set done, go to IDLE.
    - Otherwise, when the count expires, idx <= (idx==LENGTH-1) ? 0 : idx+1, and go to ISSUE.
- Timing with waitrequest=0:
  - First avm_write is asserted the cycle after the enabling CTRL write.
  - Consecutive write acceptances are exactly PERIOD cycles apart (PERIOD=1 gives back-to-back writes).
  - The one-shot done flag rises PERIOD cycles after the last acceptance.
- busy=1 in ISSUE and WAIT.
- Disable mid-run (CTRL enable=0):
  - In WAIT: go to IDLE next cycle; done is not set.
  - In ISSUE: hold the pending write until it is accepted, then go to IDLE. An Avalon request is never withdrawn.
- CTRL write with enable=1 while busy: only the oneshot bit updates; the sequence is not restarted.
- Table or PERIOD writes while running: take effect at the next ISSUE or next counter load. The in-flight avm_writedata is never changed.
- LENGTH reduced below idx+1 while running: the next advance wraps idx to 0.
- Slave write and FSM update to CTRL.enable in the same cycle: the slave write wins, except that a pending ISSUE still completes.

Optional Feature:
- Macro: HELEN_LED_SEQ_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, level) and CTRL[2] irq_en (reset 0).
  - irq = done & irq_en, registered; it rises one cycle after done sets.
  - irq clears one cycle after the STATUS write that clears done.
- Not defined:
  - No irq port.
  - CTRL[2] reads 0 and writes to it are ignored.

Decomposition:
- Package helen_led_seq_pkg holds:
  - register offset constants (CTRL=0, PERIOD=1, LENGTH=2, STATUS=3, TABLE_BASE=8);
  - the FSM state typedef {IDLE, ISSUE, WAIT};
  - CTRL/STATUS bit-index constants.
- One sub-module, helen_led_seq_timer: loadable PERIOD_W-bit down-counter with load, enable and expire outputs. It also applies the 0-to-1 period fix-up.

Test Plan:
- Loop: table={01,02,04,08}, LENGTH=4, PERIOD=5, CTRL=1, waitrequest=0 → writedata sequence 01,02,04,08,01…; acceptances every 5 cycles; first avm_write 1 cycle after the CTRL write.
- One-shot: LENGTH=3, CTRL=3 → exactly 3 writes; done=1 and enable=0 5 cycles after the 3rd acceptance; a STATUS write clears done. With HELEN_LED_SEQ_IRQ_EN and irq_en=1, irq follows done with a 1-cycle lag.
- Stall: waitrequest held high 7 cycles during ISSUE → avm_write and avm_writedata stable for all 7 cycles; accepted on the 8th; the next write comes PERIOD cycles later.
- Disable while stalled: CTRL=0 written during ISSUE with waitrequest=1 → the write stays asserted until accepted, then IDLE, busy=0, no further writes.
- Clamp/edge: PERIOD=0, LENGTH=0 → a single entry (pattern[0]) is rewritten every cycle. LENGTH=15 → idx wraps after DEPTH-1.
- Reset mid-WAIT: reset asserted 1 cycle → next cycle avm_write=0, STATUS=0, CTRL=0, and table reads return 0.
